// File: rtl/dense_layer_sequencer_pkg.sv
// rtl/dense_layer_sequencer_pkg.sv - shared state encoding and ReLU helper for the dense sequencer
package dense_layer_sequencer_pkg;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_ISSUE = 4'd1,
      ST_WAIT  = 4'd2,
      ST_WRITE = 4'd3,
      ST_DONE  = 4'd4,
      ST_ERR   = 4'd5
   } seq_state_t;

   // True when ReLU forces the value to zero; width-agnostic, it only needs the sign bit.
   function automatic logic relu_clamps(input logic relu_en, input logic sign_bit);
      return relu_en & sign_bit;
   endfunction

endpackage

// File: rtl/dense_layer_sequencer_if.sv
// rtl/dense_layer_sequencer_if.sv - command, engine, buffer-write and status bundle of the sequencer
interface dense_layer_sequencer_if #(
   parameter int N       = 16,
   parameter int NIDX_W  = 8,
   parameter int ADDR_W  = 16,
   parameter int OADDR_W = 8
);
   logic                      cmd_valid;
   logic                      cmd_ready;
   logic [NIDX_W-1:0]         cmd_num_neurons;
   logic [ADDR_W-1:0]         cmd_num_inputs;
   logic [ADDR_W-1:0]         cmd_w_base;
   logic [OADDR_W-1:0]        cmd_out_base;
   logic                      cmd_relu;
   logic                      eng_start;
   logic [ADDR_W-1:0]         eng_w_base;
   logic [NIDX_W-1:0]         eng_b_idx;
   logic                      eng_done;
   logic signed [N-1:0]       eng_result;
   logic                      wr_en;
   logic [OADDR_W-1:0]        wr_addr;
   logic [N-1:0]              wr_data;
   logic                      busy;
   logic                      layer_done;
   logic                      err_timeout;
   logic                      err_clr;

   // Sequencer side.
   modport master (
      input  cmd_valid, cmd_num_neurons, cmd_num_inputs, cmd_w_base, cmd_out_base, cmd_relu,
      input  eng_done, eng_result, err_clr,
      output cmd_ready, eng_start, eng_w_base, eng_b_idx,
      output wr_en, wr_addr, wr_data, busy, layer_done, err_timeout
   );

   // Accelerator FSM, dense engine and activation buffer side.
   modport slave (
      output cmd_valid, cmd_num_neurons, cmd_num_inputs, cmd_w_base, cmd_out_base, cmd_relu,
      output eng_done, eng_result, err_clr,
      input  cmd_ready, eng_start, eng_w_base, eng_b_idx,
      input  wr_en, wr_addr, wr_data, busy, layer_done, err_timeout
   );
endinterface

// File: rtl/dense_layer_sequencer.sv
// rtl/dense_layer_sequencer.sv - steps one shared dense engine across all neurons of a layer
module dense_layer_sequencer
   import dense_layer_sequencer_pkg::*;
#(
   parameter int N       = 16,
   parameter int NIDX_W  = 8,
   parameter int ADDR_W  = 16,
   parameter int OADDR_W = 8,
   parameter int TIMEOUT = 1024
) (
   input  logic                   clk,
   input  logic                   reset,
   dense_layer_sequencer_if.master bus
);

   localparam int CNT_W = $clog2(TIMEOUT);

   seq_state_t state, state_d;

   logic [NIDX_W-1:0]  num_neurons_q;
   logic [ADDR_W-1:0]  num_inputs_q;
   logic               relu_q;
   logic [NIDX_W-1:0]  k;
   logic [ADDR_W-1:0]  wptr;
   logic [OADDR_W-1:0] optr;
   logic [CNT_W-1:0]   wd_cnt;
   logic [N-1:0]       result_q;
   logic               err_q;

   logic accept;
   logic last_neuron;
   logic expire;

   assign accept      = bus.cmd_valid && (state == ST_IDLE);
   assign last_neuron = ((k + NIDX_W'(1)) == num_neurons_q);
   // eng_done has priority over expiry, so expiry is only acted on when no done arrives.
   assign expire      = (wd_cnt == CNT_W'(TIMEOUT - 1));

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_d;
   end

   // Next-state logic and state-decoded strobes.
   always_comb begin
      state_d        = state;
      bus.cmd_ready  = 1'b0;
      bus.eng_start  = 1'b0;
      bus.wr_en      = 1'b0;
      bus.busy       = 1'b1;
      bus.layer_done = 1'b0;
      case (state)
         ST_IDLE: begin
            bus.cmd_ready = 1'b1;
            bus.busy      = 1'b0;
            if (accept) state_d = (bus.cmd_num_neurons == '0) ? ST_DONE : ST_ISSUE;
         end
         ST_ISSUE: begin
            bus.eng_start = 1'b1;
            state_d       = ST_WAIT;
         end
         ST_WAIT: begin
            if (bus.eng_done)  state_d = ST_WRITE;
            else if (expire)   state_d = ST_ERR;
         end
         ST_WRITE: begin
            bus.wr_en = 1'b1;
            state_d   = last_neuron ? ST_DONE : ST_ISSUE;
         end
         ST_DONE: begin
            bus.layer_done = 1'b1;
            state_d        = ST_IDLE;
         end
         ST_ERR: begin
            if (bus.err_clr) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Command latch, neuron/address pointers, watchdog counter and result capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         num_neurons_q <= '0;
         num_inputs_q  <= '0;
         relu_q        <= 1'b0;
         k             <= '0;
         wptr          <= '0;
         optr          <= '0;
         wd_cnt        <= '0;
         result_q      <= '0;
      end else begin
         if (accept) begin
            num_neurons_q <= bus.cmd_num_neurons;
            num_inputs_q  <= bus.cmd_num_inputs;
            relu_q        <= bus.cmd_relu;
            k             <= '0;
            wptr          <= bus.cmd_w_base;
            optr          <= bus.cmd_out_base;
         end
         if (state == ST_ISSUE)     wd_cnt <= '0;
         else if (state == ST_WAIT) wd_cnt <= wd_cnt + CNT_W'(1);
         if (state == ST_WAIT && bus.eng_done) result_q <= bus.eng_result;
         // Weight base advances by the stride each neuron, so no multiplier is needed.
         if (state == ST_WRITE && !last_neuron) begin
            k    <= k + NIDX_W'(1);
            wptr <= wptr + num_inputs_q;
            optr <= optr + OADDR_W'(1);
         end
      end
   end

   // Sticky watchdog flag; a fresh expiry outranks a simultaneous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                          err_q <= 1'b0;
      else if (state == ST_WAIT && !bus.eng_done && expire) err_q <= 1'b1;
      else if (bus.err_clr)                               err_q <= 1'b0;
   end

   assign bus.eng_w_base  = wptr;
   assign bus.eng_b_idx   = k;
   assign bus.wr_addr     = optr;
   assign bus.wr_data     = relu_clamps(relu_q, result_q[N-1]) ? '0 : result_q;
   assign bus.err_timeout = err_q;

endmodule
